// File: rtl/decoder_pkg.sv
// Shared types and defaults for the decoder/scan block.
// Scan mode is compiled in only when DECODER_SCAN_EN is defined.
package decoder_pkg;

    localparam int SEL_W_DEF = 3;
    localparam int DWELL_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DECODE = 2'b01,
        ST_SCAN   = 2'b10
    } state_t;

    // Callers truncate to their own output width; SEL_W never exceeds 6.
    function automatic logic [63:0] onehot64(input logic [5:0] idx);
        onehot64 = 64'd1 << idx;
    endfunction

endpackage

// File: rtl/dec_dwell_cnt.sv
// Scan position and dwell timer: index advances once every DWELL run cycles,
// wrap pulses together with the index rolling over to 0.
module dec_dwell_cnt
    import decoder_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] start,
    input  logic             run,
    output logic [SEL_W-1:0] index,
    output logic             wrap
);

    localparam logic [7:0] DWELL_TC = 8'(DWELL - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
            cnt   <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            index <= start;
            cnt   <= DWELL_TC;
            wrap  <= 1'b0;
        end else if (run) begin
            if (cnt == 8'd0) begin
                cnt   <= DWELL_TC;
                index <= index + SEL_W'(1);
                wrap  <= &index;
            end else begin
                cnt  <= cnt - 8'd1;
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/decoder_n_scan.sv
// One-hot decoder with optional auto-scan mode (macro DECODER_SCAN_EN).
// Without the macro, mode is ignored and the block only decodes.
//
// state     | meaning
// ----------+--------------------------------------------------
// ST_IDLE   | disabled, out = 0
// ST_DECODE | out = one-hot of last d qualified by d_valid
// ST_SCAN   | out walks bits upward, DWELL cycles per bit
// 2'b11     | unreachable, falls back to ST_IDLE
module decoder_n_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DWELL = DWELL_DEF,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic             d_valid,
    input  logic [SEL_W-1:0] d,
    output logic [OUT_W-1:0] out,
    output logic             scan_wrap,
    output logic [1:0]       state_o
);

    state_t           state_q;
    state_t           state_d;
    logic [OUT_W-1:0] dec_q;
    logic [OUT_W-1:0] d_hot;
    logic             scan_mode;

    assign d_hot = OUT_W'(onehot64(6'(d)));

`ifdef DECODER_SCAN_EN
    assign scan_mode = mode;
`else
    logic       unused_mode;
    logic [7:0] unused_dwell;
    assign scan_mode    = 1'b0;
    assign unused_mode  = mode;
    assign unused_dwell = 8'(DWELL);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE, ST_DECODE, ST_SCAN: begin
                if (enable) begin
                    state_d = scan_mode ? ST_SCAN : ST_DECODE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode register is cleared whenever DECODE is (re)entered without a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= '0;
        end else if (state_d == ST_DECODE) begin
            if (d_valid) begin
                dec_q <= d_hot;
            end else if (state_q != ST_DECODE) begin
                dec_q <= '0;
            end
        end else begin
            dec_q <= '0;
        end
    end

`ifdef DECODER_SCAN_EN
    logic             dw_load;
    logic             dw_run;
    logic             dw_wrap;
    logic [SEL_W-1:0] scan_idx;

    assign dw_load = (state_d == ST_SCAN) && (state_q != ST_SCAN);
    assign dw_run  = (state_d == ST_SCAN) && (state_q == ST_SCAN);

    dec_dwell_cnt #(
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .load  (dw_load),
        .start (d),
        .run   (dw_run),
        .index (scan_idx),
        .wrap  (dw_wrap)
    );

    // Both sources are registers; dec_q is held at 0 while scanning.
    assign out       = (state_q == ST_SCAN) ? OUT_W'(onehot64(6'(scan_idx))) : dec_q;
    assign scan_wrap = dw_wrap;
`else
    assign out       = dec_q;
    assign scan_wrap = 1'b0;
`endif

    assign state_o = state_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Randomized scoreboard bench for decoder_n_scan (SEL_W=3, DWELL=2).
module tb_decoder_n_scan;

    localparam int SEL_W = 3;
    localparam int DWELL = 2;
    localparam int OUT_W = 8;
`ifdef DECODER_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             enable = 1'b0;
    logic             mode = 1'b0;
    logic             d_valid = 1'b0;
    logic [SEL_W-1:0] d = '0;
    logic [OUT_W-1:0] out;
    logic             scan_wrap;
    logic [1:0]       state_o;

    decoder_n_scan #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .d_valid   (d_valid),
        .d         (d),
        .out       (out),
        .scan_wrap (scan_wrap),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [1:0]       st;
        logic [OUT_W-1:0] out;
        logic             wrap;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: state as 0 idle / 1 decode / 2 scan, lit bit index
    // (-1 = none), scan position and how many cycles it has been shown.
    int m_st = 0;
    int m_hot = -1;
    int m_pos = 0;
    int m_held = 0;
    bit m_wrap = 1'b0;

    task automatic apply(input bit r, input bit e, input bit m, input bit v,
                         input int dd, input string tag);
        exp_t x;
        @(negedge clk);
        rst = r; enable = e; mode = m; d_valid = v; d = SEL_W'(dd);
        m_wrap = 1'b0;
        if (r) begin
            m_st = 0; m_hot = -1; m_pos = 0; m_held = 0;
        end else if (!e) begin
            m_st = 0; m_hot = -1;
        end else if (SCAN_EN && m) begin
            if (m_st != 2) begin
                m_pos = dd; m_held = 1;
            end else if (m_held == DWELL) begin
                m_pos  = (m_pos + 1) % OUT_W;
                m_held = 1;
                m_wrap = (m_pos == 0);
            end else begin
                m_held++;
            end
            m_hot = m_pos;
            m_st  = 2;
        end else begin
            if (v) m_hot = dd;
            else if (m_st != 1) m_hot = -1;
            m_st = 1;
        end
        x.tag  = tag;
        x.st   = 2'(m_st);
        x.out  = '0;
        if (m_hot >= 0) x.out[m_hot] = 1'b1;
        x.wrap = m_wrap;
        sb.push_back(x);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++;
                if (out !== e.out || scan_wrap !== e.wrap || state_o !== e.st) begin
                    miscompares++;
                    $display("FAIL %s: got out=%b wrap=%b state=%b, expected out=%b wrap=%b state=%b",
                             e.tag, out, scan_wrap, state_o, e.out, e.wrap, e.st);
                end
            end
        end
    end

    initial begin
        bit cm;
        cm = 1'b0;

        apply(1, 0, 0, 0, 0, "reset");
        apply(1, 1, 1, 1, 7, "reset_priority");

        apply(0, 1, 0, 1, 5, "decode_d5");
        for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, $urandom_range(7), "decode_hold");
        apply(0, 0, 0, 1, 2, "disable_idle");
        apply(0, 1, 0, 0, 4, "decode_entry_zero");
        apply(0, 1, 0, 1, 0, "decode_d0");
        apply(0, 1, 0, 1, 7, "decode_d7");

        apply(1, 0, 0, 0, 0, "reset2");
        apply(0, 1, 1, 0, 6, "scan_entry_d6");
        for (int i = 0; i < 6; i++) apply(0, 1, 1, 1, $urandom_range(7), "scan_walk");
        apply(0, 0, 1, 0, 0, "scan_disable");

        apply(0, 1, 1, 0, 0, "scan_entry_d0");
        for (int i = 0; i < 6; i++) apply(0, 1, 1, 0, 0, "scan_to_idx3");
        apply(1, 1, 1, 1, 5, "reset_mid_scan");

        apply(0, 1, 0, 1, 1, "decode_d1");
        apply(0, 1, 0, 0, 2, "decode_hold_d1");
        apply(0, 1, 1, 0, 2, "decode_to_scan");
        apply(0, 1, 1, 0, 5, "scan_ignore_d");
        apply(0, 1, 0, 0, 0, "scan_to_decode");

        apply(1, 0, 0, 0, 0, "reset3");
        apply(0, 1, 1, 1, 3, "mode1_d3");
        apply(0, 1, 1, 0, 3, "mode1_hold");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 6) cm = ~cm;
            apply($urandom_range(99) < 2, $urandom_range(99) < 93, cm,
                  $urandom_range(99) < 40, $urandom_range(OUT_W - 1), "random");
        end

        @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected responses never compared, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_n_scan.md
DECODER_N_SCAN -- requirements
Module: decoder_n_scan

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select width; legal range 1..6.
REQ-002 SHALL have parameter DWELL, default 1, cycles each output is held in scan mode; legal range 1..255.
REQ-003 SHALL derive localparam OUT_W = 2**SEL_W, output width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, block enable; low forces idle.
REQ-007 SHALL have port mode, input, 1, 0 = decode, 1 = scan.
REQ-008 SHALL have port d_valid, input, 1, strobe qualifying d in decode mode.
REQ-009 SHALL have port d, input, SEL_W, select index; scan start index on scan entry.
REQ-010 SHALL have port out, output, OUT_W, registered one-hot or all-zero output.
REQ-011 SHALL have port scan_wrap, output, 1, one-cycle pulse on scan wrap-around.
REQ-012 SHALL have port state_o, output, 2, current FSM state encoding.

Function
REQ-013 SHALL implement FSM states IDLE=2'b00, DECODE=2'b01, SCAN=2'b10; 2'b11 unreachable, recovers to IDLE.
REQ-014 SHALL transition from any state to IDLE when enable=0, with out=0 on the following cycle.
REQ-015 SHALL transition from IDLE to DECODE when enable=1 and mode=0, and to SCAN when enable=1 and mode=1.
REQ-016 SHALL switch DECODE<->SCAN one cycle after mode changes while enable=1.
REQ-017 SHALL, in DECODE, register out = one-hot(d) one cycle after a cycle with d_valid=1 (latency 1), holding out otherwise.
REQ-018 SHALL keep out=0 on entering DECODE until the first d_valid.
REQ-019 SHALL, on entering SCAN, load the scan index from d and drive out = one-hot(index) on the next cycle.
REQ-020 SHALL hold each scan index for exactly DWELL cycles, then increment it by 1 modulo OUT_W.
REQ-021 SHALL pulse scan_wrap for one cycle coincident with out changing from bit OUT_W-1 to bit 0.
REQ-022 SHALL ignore d_valid and d in SCAN except on scan entry.
REQ-023 SHALL give enable=0 priority over mode and d_valid, and rst priority over all inputs.
REQ-024 SHALL never assert more than one bit of out; no X on out in any state.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, set state IDLE, out=0, scan_wrap=0, scan index 0, dwell counter 0.
REQ-026 SHALL abort an in-progress scan or decode on rst mid-operation, without a scan_wrap pulse.

Configuration
REQ-027 SHALL compile in scan mode only when macro DECODER_SCAN_EN is defined.
REQ-028 SHALL, without DECODER_SCAN_EN, treat mode as 0, never enter SCAN, hold scan_wrap=0 and omit the dwell counter.

Structure
REQ-029 SHALL place the state enum, state encodings and SEL_W/DWELL defaults in package decoder_pkg.
REQ-030 SHALL implement the dwell timer and scan index as sub-module dec_dwell_cnt (inputs clk, rst, load, start index, run; outputs index, wrap).

Verification
REQ-031 SHALL cover (SEL_W=3): rst then enable=1, mode=0, d_valid=1, d=3'b101 -> out=8'b00100000 one cycle later, held after d_valid drops.
REQ-032 SHALL cover (SEL_W=3): enable=1 in DECODE, then enable=0 -> out=8'b00000000 next cycle, state_o=2'b00.
REQ-033 SHALL cover (SEL_W=3, DWELL=2): mode=1, d=3'b110 -> out 8'b01000000 for 2 cycles, 8'b10000000 for 2 cycles, then 8'b00000001 with scan_wrap=1 for one cycle.
REQ-034 SHALL cover (SEL_W=3, DWELL=2): rst asserted mid-scan at index 3 -> out=0, state_o=2'b00, scan_wrap=0 next cycle.
REQ-035 SHALL cover (SEL_W=3): mode 0->1 while in DECODE with d=3'b010 -> SCAN entered next cycle, scan starts at out=8'b00000100.
REQ-036 SHALL cover (SEL_W=3): build without DECODER_SCAN_EN, mode=1, d_valid=1, d=3'b011 -> out=8'b00001000, state_o=2'b01, scan_wrap stays 0.
